// File: rtl/rr_mux4_arbiter_if.sv
// Request/data bus between four requesters and the round-robin mux arbiter.
// The master side drives requests and data; the slave (arbiter) returns grant, select and muxed bit.
interface rr_mux4_arbiter_if;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] S;
  logic       valid;
  logic       F;

  modport master (
    output req,
    output din,
    input  gnt,
    input  S,
    input  valid,
    input  F
  );

  modport slave (
    input  req,
    input  din,
    output gnt,
    output S,
    output valid,
    output F
  );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter owning a shared 4:1 one-bit mux path.
// A holder is pre-empted after MAX_HOLD cycles only if someone else is waiting.
module rr_mux4_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input logic               clk,
  input logic               rst,
  rr_mux4_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] CNT_MAX = 4'(MAX_HOLD - 1);

  state_t     state_q;
  logic [3:0] gnt_q;
  logic [1:0] s_q;
  logic [1:0] ptr_q;
  logic [3:0] cnt_q;

  // While granted, any re-arbitration starts just past the current owner.
  logic [1:0] base;
  assign base = (state_q == GRANT) ? s_q + 2'd1 : ptr_q;

  logic [1:0] cand_idx [4];
  logic [3:0] cand_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand_idx[gi] = base + 2'(gi);
      assign cand_hit[gi] = bus.req[cand_idx[gi]];
    end
  endgenerate

  logic [1:0] win_idx;
  always_comb begin
    win_idx = cand_idx[0];
    for (int i = 3; i >= 0; i--) begin
      if (cand_hit[i]) win_idx = cand_idx[i];
    end
  end

  logic any_req;
  logic others_waiting;
  logic owner_released;
  logic rotate;

  assign any_req        = |bus.req;
  assign others_waiting = |(bus.req & ~(4'b0001 << s_q));
  assign owner_released = ~bus.req[s_q];
  assign rotate         = (cnt_q == CNT_MAX) && others_waiting;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      s_q     <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= GRANT;
            s_q     <= win_idx;
            gnt_q   <= 4'b0001 << win_idx;
            cnt_q   <= 4'd0;
          end
        end
        GRANT: begin
          if (owner_released || rotate) begin
            ptr_q <= s_q + 2'd1;
            if (any_req) begin
              s_q   <= win_idx;
              gnt_q <= 4'b0001 << win_idx;
              cnt_q <= 4'd0;
            end else begin
              state_q <= IDLE;
              gnt_q   <= 4'b0000;
            end
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.S     = s_q;
  assign bus.valid = (state_q == GRANT);
  assign bus.F     = (state_q == GRANT) ? bus.din[s_q] : 1'b0;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench for rr_mux4_arbiter: table-driven cycle vectors plus a
// round-robin fairness sequence, all checked through an expected-value queue.
module tb_rr_mux4_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       valid;
    logic       f;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   txn;

  rr_mux4_arbiter_if bus();

  rr_mux4_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] d,
                              input logic [3:0] g, input logic [1:0] s,
                              input logic v, input logic f);
    vec_t e;
    e.rst = r; e.req = rq; e.din = d; e.gnt = g; e.s = s; e.valid = v; e.f = f;
    tbl.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s txn=%0d: got %b required %b", name, txn, act, req_v);
    end
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    exp_q.push_back(v);
    rst     = v.rst;
    bus.req = v.req;
    bus.din = v.din;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("gnt",   bus.gnt,          e.gnt);
    chk("S",     {2'b00, bus.S},   {2'b00, e.s});
    chk("valid", {3'b000, bus.valid}, {3'b000, e.valid});
    chk("F",     {3'b000, bus.F},  {3'b000, e.f});
    $display("txn %0d rst=%b req=%b din=%b -> gnt=%b S=%0d valid=%b F=%b",
             txn, e.rst, e.req, e.din, bus.gnt, bus.S, bus.valid, bus.F);
    txn++;
  endtask

  initial begin
    vec_t v;
    logic [3:0] d;
    int idx;
    errors = 0; checks = 0; txn = 0;
    rst = 1'b1; bus.req = 4'b0000; bus.din = 4'b0000;

    // Reset with all requests high, then first grant to A
    add(1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1111, 4'b1111, 4'b0001, 2'd0, 1, 1);
    // Single requester C held indefinitely, then released to idle
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1);
    add(0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 0, 0);
    // Back-to-back release A -> D, then wrap D -> A
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1001, 4'b1001, 4'b0001, 2'd0, 1, 1);
    add(0, 4'b1000, 4'b1001, 4'b1000, 2'd3, 1, 1);
    add(0, 4'b0001, 4'b0010, 4'b0001, 2'd0, 1, 0);
    // A holds with B waiting, rotated out after 4 cycles
    add(0, 4'b0011, 4'b0010, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b0011, 4'b0011, 4'b0001, 2'd0, 1, 1);
    add(0, 4'b0011, 4'b0010, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b0011, 4'b0010, 4'b0010, 2'd1, 1, 1);
    // Reset while C holds with cnt=2, then A wins from pointer 0
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1);
    add(0, 4'b1111, 4'b0100, 4'b0100, 2'd2, 1, 1);
    add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1, 0);
    add(1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1111, 4'b1110, 4'b0001, 2'd0, 1, 0);

    foreach (tbl[i]) step(tbl[i]);

    // Fairness: all four requesting from reset, each holds exactly 4 cycles
    v.rst = 1; v.req = 4'b1111; v.din = 4'b0000;
    v.gnt = 4'b0000; v.s = 2'd0; v.valid = 0; v.f = 0;
    step(v);
    for (int k = 0; k < 17; k++) begin
      d   = 4'($urandom_range(0, 15));
      idx = (k / 4) % 4;
      v.rst = 0; v.req = 4'b1111; v.din = d;
      v.gnt = 4'b0001 << idx; v.s = 2'(idx); v.valid = 1; v.f = d[idx];
      step(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
